// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - producer and two-consumer stream bundle for stream_demux
// Ports: none; the signals below are grouped by modport.
//   slave  : demux side; takes producer word/select and consumer readies,
//            drives ready_out, both channel outputs and both transfer counters.
//   master : environment side, the mirror of slave.
interface stream_demux_if #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
);
  logic                  valid_in;
  logic                  ready_out;
  logic                  sel_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_a_out;
  logic                  ready_a_in;
  logic [DATA_WIDTH-1:0] data_a_out;
  logic                  valid_b_out;
  logic                  ready_b_in;
  logic [DATA_WIDTH-1:0] data_b_out;
  logic [CNT_WIDTH-1:0]  count_a_out;
  logic [CNT_WIDTH-1:0]  count_b_out;

  modport slave (
    input  valid_in, sel_in, data_in, ready_a_in, ready_b_in,
    output ready_out, valid_a_out, data_a_out, valid_b_out, data_b_out,
           count_a_out, count_b_out
  );

  modport master (
    output valid_in, sel_in, data_in, ready_a_in, ready_b_in,
    input  ready_out, valid_a_out, data_a_out, valid_b_out, data_b_out,
           count_a_out, count_b_out
  );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-2 stream demultiplexer with per-channel transfer counters
// Ports:
//   clk_in   : clock, all state on rising edge
//   rst_n_in : asynchronous active-low reset
//   clear_in : synchronous clear of both transfer counters
//   bus      : stream_demux_if.slave; producer word + select in, channel A/B
//              one-entry output registers with valid/ready, and counters out
module stream_demux #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 clear_in,
  stream_demux_if.slave        bus
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]            state_a;
  logic [0:0]            state_b;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [CNT_WIDTH-1:0]  count_a;
  logic [CNT_WIDTH-1:0]  count_b;

  logic room_a;
  logic room_b;
  logic accept;
  logic accept_a;
  logic accept_b;
  logic drain_a;
  logic drain_b;

  // A channel can take a word if it is empty or its current word leaves this
  // cycle; that is what gives one word per cycle per channel.
  assign room_a = (state_a == EMPTY) | bus.ready_a_in;
  assign room_b = (state_b == EMPTY) | bus.ready_b_in;

  // Only the selected channel gates the producer, so a stalled channel never
  // blocks words routed to the other one.
  assign bus.ready_out = bus.sel_in ? room_a : room_b;

  assign accept   = bus.valid_in & bus.ready_out;
  assign accept_a = accept &  bus.sel_in;
  assign accept_b = accept & ~bus.sel_in;

  assign drain_a = (state_a == FULL) & bus.ready_a_in;
  assign drain_b = (state_b == FULL) & bus.ready_b_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_a <= EMPTY;
      data_a  <= '0;
    end else if (accept_a) begin
      // covers the simultaneous drain+accept case: stays FULL with new word
      state_a <= FULL;
      data_a  <= bus.data_in;
    end else if (drain_a) begin
      state_a <= EMPTY;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_b <= EMPTY;
      data_b  <= '0;
    end else if (accept_b) begin
      state_b <= FULL;
      data_b  <= bus.data_in;
    end else if (drain_b) begin
      state_b <= EMPTY;
    end
  end

  // clear takes priority over a drain in the same cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_a <= '0;
      count_b <= '0;
    end else if (clear_in) begin
      count_a <= '0;
      count_b <= '0;
    end else begin
      if (drain_a) count_a <= count_a + 1'b1;
      if (drain_b) count_b <= count_b + 1'b1;
    end
  end

  assign bus.valid_a_out = (state_a == FULL);
  assign bus.valid_b_out = (state_b == FULL);
  assign bus.data_a_out  = data_a;
  assign bus.data_b_out  = data_b;
  assign bus.count_a_out = count_a;
  assign bus.count_b_out = count_b;

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - randomized self-checking bench for stream_demux against a queue model
module tb_stream_demux;

  logic clk_in;
  logic rst_n_in;
  logic clear_in;

  int checks;
  int errors;

  stream_demux_if #(.DATA_WIDTH(4), .CNT_WIDTH(8)) bus ();
  stream_demux_if #(.DATA_WIDTH(4), .CNT_WIDTH(2)) bus_w ();

  // narrow-counter copy sees exactly the same stimulus
  assign bus_w.valid_in   = bus.valid_in;
  assign bus_w.sel_in     = bus.sel_in;
  assign bus_w.data_in    = bus.data_in;
  assign bus_w.ready_a_in = bus.ready_a_in;
  assign bus_w.ready_b_in = bus.ready_b_in;

  stream_demux #(.DATA_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear_in (clear_in),
    .bus      (bus)
  );

  stream_demux #(.DATA_WIDTH(4), .CNT_WIDTH(2)) dut_w (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear_in (clear_in),
    .bus      (bus_w)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // reference model: each channel is a queue of words waiting for its consumer,
  // plus plain integer counts of completed handshakes
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  int         cnt_a;
  int         cnt_b;
  logic       last_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    cnt_a = 0;
    cnt_b = 0;
  endtask

  task automatic check_outputs();
    check_eq("valid_a", bus.valid_a_out, q_a.size() > 0);
    check_eq("valid_b", bus.valid_b_out, q_b.size() > 0);
    if (q_a.size() > 0) check_eq("data_a", bus.data_a_out, q_a[0]);
    if (q_b.size() > 0) check_eq("data_b", bus.data_b_out, q_b[0]);
    check_eq("count_a", bus.count_a_out, cnt_a % 256);
    check_eq("count_b", bus.count_b_out, cnt_b % 256);
    check_eq("count_a_w", bus_w.count_a_out, cnt_a % 4);
    check_eq("count_b_w", bus_w.count_b_out, cnt_b % 4);
  endtask

  // one clock cycle: drive at negedge, check just after, advance model at posedge
  task automatic step(input logic v, input logic s, input logic [3:0] d,
                      input logic ra, input logic rb, input logic clr);
    logic exp_ready;
    logic take_a;
    logic take_b;
    @(negedge clk_in);
    bus.valid_in   = v;
    bus.sel_in     = s;
    bus.data_in    = d;
    bus.ready_a_in = ra;
    bus.ready_b_in = rb;
    clear_in       = clr;
    #1;
    exp_ready = s ? (q_a.size() == 0 || ra) : (q_b.size() == 0 || rb);
    check_eq("ready_out", bus.ready_out, exp_ready);
    check_eq("ready_out_w", bus_w.ready_out, exp_ready);
    check_outputs();
    last_ready = exp_ready;
    take_a = v && exp_ready && s;
    take_b = v && exp_ready && !s;
    @(posedge clk_in);
    if (q_a.size() > 0 && ra) begin void'(q_a.pop_front()); cnt_a++; end
    if (q_b.size() > 0 && rb) begin void'(q_b.pop_front()); cnt_b++; end
    if (clr) begin cnt_a = 0; cnt_b = 0; end
    if (take_a) q_a.push_back(d);
    if (take_b) q_b.push_back(d);
  endtask

  initial begin
    logic       v, s, ra, rb, clr;
    logic [3:0] d;
    checks = 0;
    errors = 0;
    model_reset();
    rst_n_in       = 1'b0;
    clear_in       = 1'b0;
    bus.valid_in   = 1'b0;
    bus.sel_in     = 1'b0;
    bus.data_in    = 4'h0;
    bus.ready_a_in = 1'b0;
    bus.ready_b_in = 1'b0;
    #12;
    check_eq("rst_data_a", bus.data_a_out, 4'h0);
    check_eq("rst_data_b", bus.data_b_out, 4'h0);
    check_outputs();
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // route one word to A, then drain it
    step(1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("route_count_a", bus.count_a_out, 8'd1);

    // stall B: 3 is held, 5 is refused until ready_b_in rises
    step(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    check_eq("stall_refuse", bus.ready_out, 1'b0);
    step(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    check_eq("stall_hold", bus.data_b_out, 4'h3);
    step(1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
    check_eq("stall_release", bus.ready_out, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("stall_next", bus.data_b_out, 4'h5);

    // B stalled full; A still accepts
    step(1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    check_eq("indep_ready", bus.ready_out, 1'b1);
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("indep_a", bus.data_a_out, 4'h7);
    check_eq("indep_b", bus.data_b_out, 4'h5);

    // back-to-back: clear counts, 16 words to A, then final drain
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      check_eq("b2b_ready", bus.ready_out, 1'b1);
    end
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("b2b_count_a", bus.count_a_out, 8'd16);

    // wrap on the 2-bit counter, then clear against a drain
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_count_w", bus_w.count_a_out, 2'd1);
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("clear_wins_w", bus_w.count_a_out, 2'd0);
    check_eq("clear_wins", bus.count_a_out, 8'd0);

    // randomized traffic; a refused word is held stable until accepted
    v = 1'b0; s = 1'b0; d = 4'h0;
    last_ready = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (!(v && !last_ready)) begin
        v = ($urandom_range(0, 3) != 0);
        s = $urandom_range(0, 1);
        d = 4'($urandom);
      end
      ra  = ($urandom_range(0, 2) != 0);
      rb  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 63) == 0);
      step(v, s, d, ra, rb, clr);
    end

    // asynchronous reset mid-cycle while A holds a word
    step(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_valid_a", bus.valid_a_out, 1'b1);
    #2;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check_eq("rst_valid_a", bus.valid_a_out, 1'b0);
    check_eq("rst_data_a2", bus.data_a_out, 4'h0);
    check_eq("rst_count_a", bus.count_a_out, 8'd0);
    check_outputs();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
